// File: rtl/coin_collect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : coin_collect_ctrl
//  Description : Per-frame coin collection scheduler. On each frame strobe it
//                snapshots the player position in world coordinates (screen x
//                plus scroll offset) and scans the coin slots one per clock.
//                Each live coin that overlaps the player is killed and adds
//                one to a saturating BCD score.
//  Ports       : Clk, Reset          - clock, synchronous active-high reset
//                frame_clk           - frame strobe, rising edge starts a scan
//                level_restart       - revive all coins, abort scan, keep score
//                process             - horizontal scroll offset
//                player_x, player_y  - player screen position
//                coin_x_bus/_y_bus   - packed coin positions, 10 bits per slot
//                coin_alive          - per-slot collectable flags
//                coins_left          - number of live coins
//                score_bcd           - collected-coin total, BCD
//                collect_pulse       - one cycle at end of a scan with hits
//                frame_done          - one cycle at end of every scan
//                busy                - scan in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_collect_ctrl #(
   parameter int NUM_COINS    = 4,
   parameter int COIN_W       = 16,
   parameter int COIN_H       = 28,
   parameter int PLAYER_W     = 16,
   parameter int PLAYER_H     = 32,
   parameter int SCORE_DIGITS = 4
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      frame_clk,
   input  logic                      level_restart,
   input  logic [9:0]                process,
   input  logic [9:0]                player_x,
   input  logic [9:0]                player_y,
   input  logic [10*NUM_COINS-1:0]   coin_x_bus,
   input  logic [10*NUM_COINS-1:0]   coin_y_bus,
   output logic [NUM_COINS-1:0]      coin_alive,
   output logic [4:0]                coins_left,
   output logic [4*SCORE_DIGITS-1:0] score_bcd,
   output logic                      collect_pulse,
   output logic                      frame_done,
   output logic                      busy
);

   localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SNAP = 2'd1;
   localparam logic [1:0] ST_SCAN = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Box extents widened to 12 bits: world x can reach 2046 and adding a box
   // width must not wrap.
   localparam logic [11:0] COIN_W12   = 12'(COIN_W);
   localparam logic [11:0] COIN_H12   = 12'(COIN_H);
   localparam logic [11:0] PLAYER_W12 = 12'(PLAYER_W);
   localparam logic [11:0] PLAYER_H12 = 12'(PLAYER_H);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COINS - 1);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             fc_d;
   logic             fc_rise;
   logic [IDX_W-1:0] idx;
   logic [10:0]      px_w;
   logic [9:0]       py;
   logic             hit_any;

   logic [9:0]       cx;
   logic [9:0]       cy;
   logic             hit;

   logic [4*SCORE_DIGITS-1:0] score_inc;
   logic [SCORE_DIGITS:0]     carry;

   // ------------------------------------------------------------------------
   // Frame strobe edge detect (registered, one cycle of latency)
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         fc_d    <= 1'b0;
         fc_rise <= 1'b0;
      end else begin
         fc_d    <= frame_clk;
         fc_rise <= frame_clk & ~fc_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state. Restart aborts any scan; strobes outside IDLE are lost.
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      if (level_restart) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (fc_rise) state_next = ST_SNAP;
            ST_SNAP: state_next = ST_SCAN;
            ST_SCAN: if (idx == LAST_IDX) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      frame_done    = (state == ST_DONE);
      collect_pulse = (state == ST_DONE) & hit_any;
      busy          = (state != ST_IDLE);
   end

   // ------------------------------------------------------------------------
   // Overlap test for the slot currently addressed (strict: touching edges
   // do not count)
   // ------------------------------------------------------------------------
   always_comb begin
      cx  = coin_x_bus[10*idx +: 10];
      cy  = coin_y_bus[10*idx +: 10];
      hit = (state == ST_SCAN) & coin_alive[idx]
          & ({1'b0, px_w} < ({2'b00, cx} + COIN_W12))
          & ({2'b00, cx}  < ({1'b0, px_w} + PLAYER_W12))
          & ({2'b00, py}  < ({2'b00, cy} + COIN_H12))
          & ({2'b00, cy}  < ({2'b00, py} + PLAYER_H12));
   end

   // ------------------------------------------------------------------------
   // BCD +1 with ripple carry. A carry out of the top digit means the score
   // is all nines, in which case the score is held instead of wrapping.
   // ------------------------------------------------------------------------
   assign carry[0] = 1'b1;

   generate
      for (genvar d = 0; d < SCORE_DIGITS; d++) begin : g_digit
         logic [3:0] digit;
         assign digit       = score_bcd[4*d +: 4];
         assign carry[d+1]  = carry[d] & (digit == 4'd9);
         assign score_inc[4*d +: 4] = !carry[d]          ? digit :
                                      (digit == 4'd9)    ? 4'd0  :
                                                           digit + 4'd1;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Datapath: snapshot, slot index, alive flags, score
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         coin_alive <= '1;
         score_bcd  <= '0;
         hit_any    <= 1'b0;
         idx        <= '0;
         px_w       <= '0;
         py         <= '0;
      end else if (level_restart) begin
         coin_alive <= '1;
         hit_any    <= 1'b0;
         idx        <= '0;
      end else begin
         if (state == ST_SNAP) begin
            px_w    <= {1'b0, player_x} + {1'b0, process};
            py      <= player_y;
            hit_any <= 1'b0;
            idx     <= '0;
         end else if (state == ST_SCAN) begin
            if (idx != LAST_IDX) begin
               idx <= idx + 1'b1;
            end
         end
         if (hit) begin
            coin_alive[idx] <= 1'b0;
            hit_any         <= 1'b1;
            if (!carry[SCORE_DIGITS]) begin
               score_bcd <= score_inc;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Live coin count
   // ------------------------------------------------------------------------
   always_comb begin
      coins_left = 5'd0;
      for (int i = 0; i < NUM_COINS; i++) begin
         coins_left = coins_left + 5'(coin_alive[i]);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_coin_collect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_collect_ctrl
//  Description : Directed self-checking bench for coin_collect_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_collect_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_clk = 1'b0;
   logic        level_restart = 1'b0;
   logic [9:0]  process = '0;
   logic [9:0]  player_x = '0;
   logic [9:0]  player_y = '0;
   logic [39:0] coin_x_bus = '0;
   logic [39:0] coin_y_bus = '0;
   logic [3:0]  coin_alive;
   logic [4:0]  coins_left;
   logic [15:0] score_bcd;
   logic        collect_pulse;
   logic        frame_done;
   logic        busy;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int exp_score = 0;

   coin_collect_ctrl dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_clk     (frame_clk),
      .level_restart (level_restart),
      .process       (process),
      .player_x      (player_x),
      .player_y      (player_y),
      .coin_x_bus    (coin_x_bus),
      .coin_y_bus    (coin_y_bus),
      .coin_alive    (coin_alive),
      .coins_left    (coins_left),
      .score_bcd     (score_bcd),
      .collect_pulse (collect_pulse),
      .frame_done    (frame_done),
      .busy          (busy)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          t;
      t = v;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_coin(input int i, input int x, input int y);
      coin_x_bus[10*i +: 10] = 10'(x);
      coin_y_bus[10*i +: 10] = 10'(y);
   endtask

   task automatic restart();
      level_restart = 1'b1;
      tick();
      level_restart = 1'b0;
   endtask

   // One frame strobe, then a fixed observation window counting pulses.
   task automatic run_frame(output int nd, output int np);
      nd = 0;
      np = 0;
      frame_clk = 1'b1;
      tick();
      frame_clk = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (frame_done)    nd++;
         if (collect_pulse) np++;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      total_cnt++;
      if (coin_alive !== 4'hF || coins_left !== 5'd4 || score_bcd !== 16'h0000 ||
          busy !== 1'b0 || frame_done !== 1'b0 || collect_pulse !== 1'b0) begin
         $display("FAIL reset: alive=%h left=%0d score=%h busy=%b fd=%b cp=%b, want F 4 0000 0 0 0",
                  coin_alive, coins_left, score_bcd, busy, frame_done, collect_pulse);
      end else pass_cnt++;
   endtask

   task automatic test_basic_hit();
      int nd = 0;
      int np = 0;
      player_x = 10'd100; player_y = 10'd300; process = 10'd0;
      set_coin(0, 100, 300);
      set_coin(1, 1000, 1000);
      set_coin(2, 1000, 1000);
      set_coin(3, 1000, 1000);
      frame_clk = 1'b1;
      tick();
      frame_clk = 1'b0;
      tick();
      tick();
      total_cnt++;
      if (coin_alive !== 4'hF || busy !== 1'b1) begin
         $display("FAIL basic_pre_scan: alive=%h busy=%b, want F 1", coin_alive, busy);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (coin_alive !== 4'hE) begin
         $display("FAIL basic_alive_cycle3: alive=%h, want E", coin_alive);
      end else pass_cnt++;
      for (int k = 0; k < 9; k++) begin
         tick();
         if (frame_done)    nd++;
         if (collect_pulse) np++;
      end
      exp_score = 1;
      total_cnt++;
      if (score_bcd !== to_bcd(exp_score) || coins_left !== 5'd3 || nd != 1 || np != 1) begin
         $display("FAIL basic_result: score=%h left=%0d done=%0d pulse=%0d, want %h 3 1 1",
                  score_bcd, coins_left, nd, np, to_bcd(exp_score));
      end else pass_cnt++;
   endtask

   task automatic test_edge_touch();
      int nd, np;
      int px [4] = '{84, 116, 100, 100};
      int py [4] = '{300, 300, 328, 268};
      restart();
      set_coin(0, 100, 300);
      for (int i = 0; i < 4; i++) begin
         player_x = 10'(px[i]);
         player_y = 10'(py[i]);
         run_frame(nd, np);
         total_cnt++;
         if (coin_alive !== 4'hF || score_bcd !== to_bcd(exp_score) || nd != 1 || np != 0) begin
            $display("FAIL edge_touch_%0d: alive=%h score=%h done=%0d pulse=%0d, want F %h 1 0",
                     i, coin_alive, score_bcd, nd, np, to_bcd(exp_score));
         end else pass_cnt++;
      end
      player_x = 10'd85;
      player_y = 10'd300;
      run_frame(nd, np);
      exp_score++;
      total_cnt++;
      if (coin_alive !== 4'hE || score_bcd !== to_bcd(exp_score) || np != 1) begin
         $display("FAIL edge_overlap1: alive=%h score=%h pulse=%0d, want E %h 1",
                  coin_alive, score_bcd, np, to_bcd(exp_score));
      end else pass_cnt++;
   endtask

   task automatic test_multi_hit();
      int nd, np;
      restart();
      process = 10'd200; player_x = 10'd200; player_y = 10'd300;
      set_coin(0, 400, 300);
      set_coin(1, 1000, 1000);
      set_coin(2, 400, 300);
      set_coin(3, 1000, 1000);
      run_frame(nd, np);
      exp_score += 2;
      total_cnt++;
      if (coin_alive !== 4'hA || coins_left !== 5'd2 || score_bcd !== to_bcd(exp_score) ||
          nd != 1 || np != 1) begin
         $display("FAIL multi_hit: alive=%h left=%0d score=%h done=%0d pulse=%0d, want A 2 %h 1 1",
                  coin_alive, coins_left, score_bcd, nd, np, to_bcd(exp_score));
      end else pass_cnt++;
   endtask

   // Second strobe arrives mid-scan; dead coins still overlap the player.
   task automatic test_busy_ignore();
      int nd = 0;
      int np = 0;
      frame_clk = 1'b1; tick();
      frame_clk = 1'b0; tick();
      frame_clk = 1'b1; tick();
      frame_clk = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (frame_done)    nd++;
         if (collect_pulse) np++;
      end
      total_cnt++;
      if (nd != 1 || np != 0 || score_bcd !== to_bcd(exp_score) || coin_alive !== 4'hA) begin
         $display("FAIL busy_ignore: done=%0d pulse=%0d score=%h alive=%h, want 1 0 %h A",
                  nd, np, score_bcd, coin_alive, to_bcd(exp_score));
      end else pass_cnt++;
   endtask

   task automatic test_restart_abort();
      int nd = 0;
      int np = 0;
      process = 10'd0; player_x = 10'd100; player_y = 10'd300;
      set_coin(0, 1000, 1000);
      set_coin(1, 100, 300);
      set_coin(2, 100, 300);
      set_coin(3, 100, 300);
      restart();
      frame_clk = 1'b1; tick();
      frame_clk = 1'b0;
      tick();
      tick();
      tick();
      total_cnt++;
      if (busy !== 1'b1 || coin_alive !== 4'hF) begin
         $display("FAIL abort_pre: busy=%b alive=%h, want 1 F", busy, coin_alive);
      end else pass_cnt++;
      level_restart = 1'b1;
      tick();
      level_restart = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || coin_alive !== 4'hF || score_bcd !== to_bcd(exp_score)) begin
         $display("FAIL abort_now: busy=%b alive=%h score=%h, want 0 F %h",
                  busy, coin_alive, score_bcd, to_bcd(exp_score));
      end else pass_cnt++;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (frame_done)    nd++;
         if (collect_pulse) np++;
      end
      total_cnt++;
      if (nd != 0 || np != 0 || coin_alive !== 4'hF || score_bcd !== to_bcd(exp_score)) begin
         $display("FAIL abort_after: done=%0d pulse=%0d alive=%h score=%h, want 0 0 F %h",
                  nd, np, coin_alive, score_bcd, to_bcd(exp_score));
      end else pass_cnt++;
   endtask

   task automatic test_saturate();
      int nd, np;
      int full;
      int rem;
      process = 10'd0; player_x = 10'd100; player_y = 10'd300;
      for (int i = 0; i < 4; i++) set_coin(i, 100, 300);
      full = (9999 - exp_score) / 4;
      rem  = (9999 - exp_score) % 4;
      for (int f = 0; f < full; f++) begin
         restart();
         frame_clk = 1'b1; tick();
         frame_clk = 1'b0;
         repeat (8) tick();
      end
      exp_score += 4 * full;
      for (int i = rem; i < 4; i++) set_coin(i, 1000, 1000);
      restart();
      run_frame(nd, np);
      exp_score += rem;
      total_cnt++;
      if (score_bcd !== to_bcd(exp_score) || score_bcd !== 16'h9999) begin
         $display("FAIL sat_reach: score=%h, want %h", score_bcd, to_bcd(exp_score));
      end else pass_cnt++;
      for (int i = 0; i < 4; i++) set_coin(i, 1000, 1000);
      set_coin(0, 100, 300);
      restart();
      run_frame(nd, np);
      total_cnt++;
      if (score_bcd !== 16'h9999 || coin_alive !== 4'hE || coins_left !== 5'd3 || np != 1) begin
         $display("FAIL sat_hold: score=%h alive=%h left=%0d pulse=%0d, want 9999 E 3 1",
                  score_bcd, coin_alive, coins_left, np);
      end else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_hit();
      test_edge_touch();
      test_multi_hit();
      test_busy_ignore();
      test_restart_abort();
      test_saturate();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
